code: RTL and testbench
=======================

CODE -- requirements
Module: code

Interface
REQ-001 Parameter ACTIVE_LOW, default 0: 0 = segment lit when bit is 1; 1 = all seg bits inverted (common-anode).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 hex  input  4  hexadecimal digit to display, 0x0-0xF.
REQ-005 en  input  1  load enable; output register updates only when en=1.
REQ-006 blank  input  1  1 = all segments off.
REQ-007 lamp_test  input  1  1 = all segments on.
REQ-008 seg  output  7  registered segment drive; seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g.

Function
REQ-009 Decode table, ACTIVE_LOW=0, value as seg[6:0] (abcdefg): 0->1111110, 1->0110000, 2->1101101, 3->1111001, 4->0110011, 5->1011011, 6->1011111, 7->1110000.
REQ-010 Decode table continued: 8->1111111, 9->1111011, A->1110111, b->0011111, C->1001110, d->0111101, E->1001111, F->1000111.
REQ-011 Decode is total over all 16 codes; no default/X output for any 4-bit input.
REQ-012 Priority on a load cycle: lamp_test > blank > hex decode.
REQ-013 lamp_test=1 loads "all on" (1111111 for ACTIVE_LOW=0).
REQ-014 blank=1 with lamp_test=0 loads "all off" (0000000 for ACTIVE_LOW=0).
REQ-015 With ACTIVE_LOW=1, every loaded value is the bitwise inverse of the ACTIVE_LOW=0 value, including all on/off.
REQ-016 Latency: seg reflects inputs sampled at rising edge N with en=1, valid immediately after edge N (1-cycle latency); no combinational input-to-seg path.
REQ-017 en=0: seg holds its previous value; hex, blank, lamp_test ignored.
REQ-018 hex changing every cycle with en=1: each value appears on seg exactly one cycle later, with no skipped or merged values.
REQ-019 Inputs are synchronous to clk; no internal synchronizers.

Reset
REQ-020 rst=1 forces seg to "all off" (0000000, or 1111111 when ACTIVE_LOW=1) immediately, without waiting for a clock edge.
REQ-021 While rst=1, seg holds "all off" regardless of en, hex, blank, lamp_test.
REQ-022 On the first rising edge after rst deasserts, normal loading per REQ-012..REQ-017 resumes.
REQ-023 Reset asserted mid-sequence discards the held value; no decode value survives reset.

Verification
REQ-024 Sweep: ACTIVE_LOW=0, en=1, blank=0, lamp_test=0, hex=0x0..0xF one per cycle -> seg matches REQ-009/REQ-010 one cycle later (e.g. 0x0->1111110, 0xA->1110111, 0xF->1000111).
REQ-025 Priority: hex=0x8, blank=1, lamp_test=1 -> 1111111; lamp_test=0 -> 0000000; blank=0 -> 1111111 from decode.
REQ-026 Hold: load hex=0x3 (1111001), then en=0 with hex=0x4 for 5 cycles -> seg stays 1111001; en=1 -> 0110011 next edge.
REQ-027 Async reset: seg=1011011 (hex 5), assert rst between edges -> seg=0000000 before the next edge; deassert -> next load resumes decode.
REQ-028 ACTIVE_LOW=1 instance: hex=0x0 -> 0000001; hex=0x1 -> 1001111; reset -> 1111111; blank -> 1111111; lamp_test -> 0000000.

Source files
------------

// File: rtl/code_if.sv
// Bus bundle for the seven-segment decoder: digit/control inputs and the registered segment drive.
interface code_if;
  logic [3:0] hex;
  logic       en;
  logic       blank;
  logic       lamp_test;
  logic [6:0] seg;

  modport master (output hex, output en, output blank, output lamp_test, input seg);
  modport slave  (input hex, input en, input blank, input lamp_test, output seg);
endinterface

// File: rtl/code.sv
// Registered hex-to-seven-segment decoder with lamp test, blanking and selectable output polarity.
module code #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  code_if.slave  bus
);

  localparam logic [6:0] SEG_ON  = 7'b1111111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] POL     = {7{ACTIVE_LOW}};

  logic [6:0] seg_q;
  logic [6:0] seg_d;
  logic [6:0] decoded;
  logic [6:0] raw;

  // Segment order is abcdefg, bit 6 = a.
  always_comb begin
    decoded = SEG_OFF;
    case (bus.hex)
      4'h0: decoded = 7'b1111110;
      4'h1: decoded = 7'b0110000;
      4'h2: decoded = 7'b1101101;
      4'h3: decoded = 7'b1111001;
      4'h4: decoded = 7'b0110011;
      4'h5: decoded = 7'b1011011;
      4'h6: decoded = 7'b1011111;
      4'h7: decoded = 7'b1110000;
      4'h8: decoded = 7'b1111111;
      4'h9: decoded = 7'b1111011;
      4'hA: decoded = 7'b1110111;
      4'hB: decoded = 7'b0011111;
      4'hC: decoded = 7'b1001110;
      4'hD: decoded = 7'b0111101;
      4'hE: decoded = 7'b1001111;
      4'hF: decoded = 7'b1000111;
    endcase
  end

  always_comb begin
    raw   = decoded;
    seg_d = seg_q;
    if (bus.lamp_test) begin
      raw = SEG_ON;
    end else if (bus.blank) begin
      raw = SEG_OFF;
    end
    if (bus.en) begin
      seg_d = raw ^ POL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_OFF ^ POL;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign bus.seg = seg_q;

endmodule

// File: tb/tb_code.sv
// Randomised and directed checks of both polarities of the decoder against a table-driven model.
module tb_code;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hex = 4'h0;
  logic       en = 1'b0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] m0;
  logic [6:0] m1;

  localparam logic [6:0] TBL [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  code_if if0 ();
  code_if if1 ();

  assign if0.hex = hex;
  assign if0.en = en;
  assign if0.blank = blank;
  assign if0.lamp_test = lamp_test;
  assign if1.hex = hex;
  assign if1.en = en;
  assign if1.blank = blank;
  assign if1.lamp_test = lamp_test;

  code #(.ACTIVE_LOW(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  code #(.ACTIVE_LOW(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  function automatic logic [6:0] model_seg(input logic [3:0] h, input logic b,
                                           input logic lt, input logic al);
    logic [6:0] v;
    if (lt) v = 7'b1111111;
    else if (b) v = 7'b0000000;
    else v = TBL[h];
    return al ? ~v : v;
  endfunction

  // Advance one edge, update the model from the inputs seen at that edge, settle.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m0 = 7'b0000000;
      m1 = 7'b1111111;
    end else if (en) begin
      m0 = model_seg(hex, blank, lamp_test, 1'b0);
      m1 = model_seg(hex, blank, lamp_test, 1'b1);
    end
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1; lamp_test = 1'b1; hex = 4'h8;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (if0.seg !== 7'b0000000) begin
      miscompares++; $display("FAIL reset_al0 seg=%b expected=%b", if0.seg, 7'b0000000);
    end
    vectors++;
    if (if1.seg !== 7'b1111111) begin
      miscompares++; $display("FAIL reset_al1 seg=%b expected=%b", if1.seg, 7'b1111111);
    end
    m0 = 7'b0000000; m1 = 7'b1111111;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (if0.seg !== 7'b0000000 || if1.seg !== 7'b1111111) begin
        miscompares++; $display("FAIL reset_hold seg0=%b seg1=%b expected=0000000/1111111", if0.seg, if1.seg);
      end
    end
    rst = 1'b0; lamp_test = 1'b0;
  endtask

  task automatic test_sweep();
    en = 1'b1; blank = 1'b0; lamp_test = 1'b0;
    for (int i = 0; i < 16; i++) begin
      hex = 4'(i);
      tick();
      vectors++;
      if (if0.seg !== m0 || if1.seg !== m1) begin
        miscompares++; $display("FAIL sweep hex=%h seg0=%b exp0=%b seg1=%b exp1=%b", i[3:0], if0.seg, m0, if1.seg, m1);
      end
    end
    vectors++;
    if (if0.seg !== 7'b1000111) begin
      miscompares++; $display("FAIL sweep_F seg=%b expected=1000111", if0.seg);
    end
  endtask

  task automatic test_priority();
    en = 1'b1; hex = 4'h8; blank = 1'b1; lamp_test = 1'b1;
    tick();
    vectors++;
    if (if0.seg !== 7'b1111111 || if1.seg !== 7'b0000000) begin
      miscompares++; $display("FAIL prio_lamp seg0=%b seg1=%b expected=1111111/0000000", if0.seg, if1.seg);
    end
    lamp_test = 1'b0;
    tick();
    vectors++;
    if (if0.seg !== 7'b0000000 || if1.seg !== 7'b1111111) begin
      miscompares++; $display("FAIL prio_blank seg0=%b seg1=%b expected=0000000/1111111", if0.seg, if1.seg);
    end
    blank = 1'b0;
    tick();
    vectors++;
    if (if0.seg !== 7'b1111111) begin
      miscompares++; $display("FAIL prio_decode seg=%b expected=1111111", if0.seg);
    end
  endtask

  task automatic test_hold();
    en = 1'b1; hex = 4'h3; blank = 1'b0; lamp_test = 1'b0;
    tick();
    vectors++;
    if (if0.seg !== 7'b1111001) begin
      miscompares++; $display("FAIL hold_load seg=%b expected=1111001", if0.seg);
    end
    en = 1'b0; hex = 4'h4;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin blank = 1'b1; lamp_test = 1'b1; end
      tick();
      vectors++;
      if (if0.seg !== 7'b1111001 || if1.seg !== 7'b0000110) begin
        miscompares++; $display("FAIL hold_cycle%0d seg0=%b seg1=%b expected=1111001/0000110", i, if0.seg, if1.seg);
      end
    end
    en = 1'b1; blank = 1'b0; lamp_test = 1'b0;
    tick();
    vectors++;
    if (if0.seg !== 7'b0110011) begin
      miscompares++; $display("FAIL hold_release seg=%b expected=0110011", if0.seg);
    end
  endtask

  task automatic test_no_comb_path();
    en = 1'b1; hex = 4'h1;
    tick();
    hex = 4'hE; lamp_test = 1'b1;
    #2;
    vectors++;
    if (if0.seg !== 7'b0110000) begin
      miscompares++; $display("FAIL no_comb seg=%b expected=0110000", if0.seg);
    end
    lamp_test = 1'b0;
  endtask

  task automatic test_async_reset();
    en = 1'b1; hex = 4'h5; blank = 1'b0; lamp_test = 1'b0;
    tick();
    vectors++;
    if (if0.seg !== 7'b1011011) begin
      miscompares++; $display("FAIL areset_load seg=%b expected=1011011", if0.seg);
    end
    #3 rst = 1'b1;
    #1;
    m0 = 7'b0000000; m1 = 7'b1111111;
    vectors++;
    if (if0.seg !== 7'b0000000 || if1.seg !== 7'b1111111) begin
      miscompares++; $display("FAIL areset_now seg0=%b seg1=%b expected=0000000/1111111", if0.seg, if1.seg);
    end
    tick();
    rst = 1'b0; hex = 4'h2;
    tick();
    vectors++;
    if (if0.seg !== 7'b1101101 || if1.seg !== 7'b0010010) begin
      miscompares++; $display("FAIL areset_resume seg0=%b seg1=%b expected=1101101/0010010", if0.seg, if1.seg);
    end
  endtask

  task automatic test_active_low();
    en = 1'b1; blank = 1'b0; lamp_test = 1'b0;
    hex = 4'h0;
    tick();
    vectors++;
    if (if1.seg !== 7'b0000001) begin
      miscompares++; $display("FAIL al1_hex0 seg=%b expected=0000001", if1.seg);
    end
    hex = 4'h1;
    tick();
    vectors++;
    if (if1.seg !== 7'b1001111) begin
      miscompares++; $display("FAIL al1_hex1 seg=%b expected=1001111", if1.seg);
    end
    blank = 1'b1;
    tick();
    vectors++;
    if (if1.seg !== 7'b1111111) begin
      miscompares++; $display("FAIL al1_blank seg=%b expected=1111111", if1.seg);
    end
    lamp_test = 1'b1;
    tick();
    vectors++;
    if (if1.seg !== 7'b0000000) begin
      miscompares++; $display("FAIL al1_lamp seg=%b expected=0000000", if1.seg);
    end
    blank = 1'b0; lamp_test = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      blank = ($urandom_range(0, 5) == 0);
      lamp_test = ($urandom_range(0, 7) == 0);
      hex = 4'($urandom);
      tick();
      vectors++;
      if (if0.seg !== m0 || if1.seg !== m1) begin
        miscompares++; $display("FAIL random%0d seg0=%b exp0=%b seg1=%b exp1=%b", i, if0.seg, m0, if1.seg, m1);
      end
    end
  endtask

  initial begin
    m0 = 7'b0000000;
    m1 = 7'b1111111;
    test_reset();
    test_sweep();
    test_priority();
    test_hold();
    test_no_comb_path();
    test_async_reset();
    test_active_low();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
